kbd_mmio: RTL
=============

Name: kbd_mmio

Overview:
- Memory-mapped keyboard peripheral feeding the io controller's read-data mux and irq line.
- Consumes bytes from the PS/2 receiver (ps2_rx): rx_data plus a one-cycle done tick.
  - Decodes make/break/extended sequences and tracks shift/caps state.
  - Translates scancodes to ASCII and buffers characters in an internal FIFO.
- CPU accesses the block through three word registers in the keyboard address region; irq is asserted while characters are pending and interrupts are enabled.

Parameters:
- FIFO_DEPTH, 16, number of buffered characters; power of two, 2..256.
- REGION, 4'h3, value of addr_in[31:28] that selects this block.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-low reset.
- rx_data  input  8  scancode byte from ps2_rx.
- rx_done_tick  input  1  one-cycle strobe; rx_data valid this cycle.
- addr_in  input  32  CPU byte address.
- data_in  input  32  CPU write data.
- wr  input  1  CPU write strobe.
- rd  input  1  CPU read strobe; pops the FIFO when the DATA register is addressed.
- mrd  output  32  read data; combinational from addr_in and current state.
- irq  output  1  level interrupt = irq_en AND fifo non-empty.

Behaviour:
- Address decode:
  - sel = (addr_in[31:28]==REGION).
  - addr_in[3:2]: 0 = DATA, 1 = STATUS, 2 = CTRL, 3 = reserved (reads 0).
  - mrd = 0 when sel=0.
- DATA read: [7:0] = FIFO head char, [8] = valid (non-empty), [31:9] = 0.
  - Empty FIFO reads 0x00000000.
- STATUS read:
  - [0] = non-empty, [1] = overflow (sticky), [2] = irq_en, [3] = shift, [4] = caps.
  - [15:8] = count, saturating at 255; rest 0.
- CTRL write (sel & wr & addr[3:2]==2):
  - data_in[0] sets irq_en.
  - data_in[1]=1 clears overflow.
  - data_in[2]=1 flushes the FIFO (count=0; pointers equal).
  - CTRL reads return {30'b0, 1'b0, irq_en}.
- Pop: a rising edge with sel & rd & addr[3:2]==0 and non-empty advances the head. No pop when empty.
- Decoder FSM, advances only on rx_done_tick:
  - IDLE: F0 -> BRK; E0 -> EXT; else make(code).
  - BRK: break(code) -> IDLE.
  - EXT: F0 -> EXTBRK; else extmake(code) -> IDLE.
  - EXTBRK: any code -> IDLE (ignored).
- Modifiers:
  - make 0x12/0x59 sets shift; break of the same code clears it.
  - make 0x58 toggles caps. Auto-repeat makes toggle again, matching PS/2 behaviour.
  - Modifier and caps keys push nothing.
- Translation, combinational, in the sub-module:
  - Letters: 0x1C=a ... standard set-2 map. Uppercase if shift XOR caps.
  - Digits 0x16..0x46 map to '1'..'0'; shift gives !@#$%^&*().
  - Space 0x29 -> 0x20; Enter 0x5A -> 0x0D; Backspace 0x66 -> 0x08; Esc 0x76 -> 0x1B.
  - Extended arrows: 0x75 -> 0x80 (up), 0x72 -> 0x81 (down), 0x6B -> 0x82 (left), 0x74 -> 0x83 (right).
  - Unmapped codes produce no push.
- Pipeline latency:
  - rx_done_tick at edge N: the FSM and translated char are registered with push_req at N+1.
  - FIFO write at N+2. mrd/irq reflect the new entry after edge N+2.
- Full FIFO:
  - push_req with count==FIFO_DEPTH and no same-cycle pop: char dropped, overflow<=1.
  - Simultaneous push and pop when full: both performed, count unchanged, no overflow.
- Pointers wrap modulo FIFO_DEPTH. Count uses log2(FIFO_DEPTH)+1 bits.
- Flush and push in the same cycle: flush wins, push dropped, overflow unaffected.
- Flush and pop in the same cycle: flush wins.
- Reset (any time, asynchronous):
  - FSM=IDLE; shift=caps=0; irq_en=0; overflow=0; count=0; pointers=0; push_req=0.
  - irq=0 and mrd is decode-only (DATA reads 0).
  - A sequence interrupted mid-way (e.g. after F0) is discarded.

Decomposition:
- Shared package/header holds:
  - register offsets: KBD_DATA=0, KBD_STATUS=1, KBD_CTRL=2;
  - scancode constants: SC_BREAK=8'hF0, SC_EXT=8'hE0, SC_LSHIFT, SC_RSHIFT, SC_CAPS;
  - arrow codes 8'h80..8'h83;
  - FSM state encodings.
- One sub-module, kbd_scan_xlate: combinational {code, ext, shift, caps} -> {ascii[7:0], valid}.
- FIFO storage is inline in kbd_mmio: a register array plus pointers.

Test Plan:
- Reset low mid-stream after F0, release, send 1C -> DATA reads 0x161 ('a', valid); no stray break effect; irq=0 until CTRL write 0x1, then irq=1.
- Send 12,1C,F0,1C,F0,12,1C -> FIFO holds 'A' (0x41) then 'a' (0x61); STATUS[15:8]=2; two DATA reads with rd pop in order, then DATA reads 0, irq drops.
- Send 58,F0,58,1C -> 'A'; caps=1 in STATUS[4]; then 12,1C -> 'a' (shift XOR caps).
- Send E0,75,E0,F0,75 -> single 0x80 pushed; break ignored; FSM returns to IDLE.
- Push 17 chars with FIFO_DEPTH=16 -> count=16, overflow=1; a pop coinciding with the 18th push keeps count=16; CTRL write 0x2 clears overflow; CTRL write 0x4 empties the FIFO.
- Check cycle timing: rx_done_tick at edge N -> STATUS[0] still 0 after N+1 and 1 after N+2; unmapped code 0x07 -> nothing pushed.

Source files
------------

// File: rtl/kbd_pkg.sv
// Shared constants for the keyboard MMIO block: register offsets, set-2 scancodes,
// arrow-key codes and the make/break decoder state encoding.
package kbd_pkg;
   localparam logic [1:0] KBD_DATA   = 2'd0;
   localparam logic [1:0] KBD_STATUS = 2'd1;
   localparam logic [1:0] KBD_CTRL   = 2'd2;

   localparam logic [7:0] SC_BREAK  = 8'hF0;
   localparam logic [7:0] SC_EXT    = 8'hE0;
   localparam logic [7:0] SC_LSHIFT = 8'h12;
   localparam logic [7:0] SC_RSHIFT = 8'h59;
   localparam logic [7:0] SC_CAPS   = 8'h58;
   localparam logic [7:0] SC_SPACE  = 8'h29;
   localparam logic [7:0] SC_ENTER  = 8'h5A;
   localparam logic [7:0] SC_BKSP   = 8'h66;
   localparam logic [7:0] SC_ESC    = 8'h76;
   localparam logic [7:0] SC_UP     = 8'h75;
   localparam logic [7:0] SC_DOWN   = 8'h72;
   localparam logic [7:0] SC_LEFT   = 8'h6B;
   localparam logic [7:0] SC_RIGHT  = 8'h74;

   localparam logic [7:0] KEY_UP    = 8'h80;
   localparam logic [7:0] KEY_DOWN  = 8'h81;
   localparam logic [7:0] KEY_LEFT  = 8'h82;
   localparam logic [7:0] KEY_RIGHT = 8'h83;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_BRK    = 2'd1,
      ST_EXT    = 2'd2,
      ST_EXTBRK = 2'd3
   } kbd_state_t;

   function automatic logic is_shift(input logic [7:0] code);
      return (code == SC_LSHIFT) || (code == SC_RSHIFT);
   endfunction
endpackage

// File: rtl/kbd_scan_xlate.sv
// Combinational set-2 scancode to ASCII translation; o_valid=0 for codes that
// produce no character (including every extended code other than the arrows).
module kbd_scan_xlate
   import kbd_pkg::*;
(
   input  logic [7:0] i_code,
   input  logic       i_ext,
   input  logic       i_shift,
   input  logic       i_caps,
   output logic [7:0] o_ascii,
   output logic       o_valid
);
   logic [7:0] w_letter;
   logic       w_is_letter;
   logic [7:0] w_digit;
   logic [7:0] w_digit_sh;
   logic       w_is_digit;

   always_comb begin
      w_letter    = 8'h00;
      w_is_letter = 1'b1;
      case (i_code)
         8'h1C: w_letter = "a";  8'h32: w_letter = "b";  8'h21: w_letter = "c";
         8'h23: w_letter = "d";  8'h24: w_letter = "e";  8'h2B: w_letter = "f";
         8'h34: w_letter = "g";  8'h33: w_letter = "h";  8'h43: w_letter = "i";
         8'h3B: w_letter = "j";  8'h42: w_letter = "k";  8'h4B: w_letter = "l";
         8'h3A: w_letter = "m";  8'h31: w_letter = "n";  8'h44: w_letter = "o";
         8'h4D: w_letter = "p";  8'h15: w_letter = "q";  8'h2D: w_letter = "r";
         8'h1B: w_letter = "s";  8'h2C: w_letter = "t";  8'h3C: w_letter = "u";
         8'h2A: w_letter = "v";  8'h1D: w_letter = "w";  8'h22: w_letter = "x";
         8'h35: w_letter = "y";  8'h1A: w_letter = "z";
         default: w_is_letter = 1'b0;
      endcase
   end

   always_comb begin
      w_digit    = 8'h00;
      w_digit_sh = 8'h00;
      w_is_digit = 1'b1;
      case (i_code)
         8'h16: begin w_digit = "1"; w_digit_sh = "!"; end
         8'h1E: begin w_digit = "2"; w_digit_sh = "@"; end
         8'h26: begin w_digit = "3"; w_digit_sh = "#"; end
         8'h25: begin w_digit = "4"; w_digit_sh = "$"; end
         8'h2E: begin w_digit = "5"; w_digit_sh = "%"; end
         8'h36: begin w_digit = "6"; w_digit_sh = "^"; end
         8'h3D: begin w_digit = "7"; w_digit_sh = "&"; end
         8'h3E: begin w_digit = "8"; w_digit_sh = "*"; end
         8'h46: begin w_digit = "9"; w_digit_sh = "("; end
         8'h45: begin w_digit = "0"; w_digit_sh = ")"; end
         default: w_is_digit = 1'b0;
      endcase
   end

   always_comb begin
      o_ascii = 8'h00;
      o_valid = 1'b0;
      if (i_ext) begin
         o_valid = 1'b1;
         case (i_code)
            SC_UP:    o_ascii = KEY_UP;
            SC_DOWN:  o_ascii = KEY_DOWN;
            SC_LEFT:  o_ascii = KEY_LEFT;
            SC_RIGHT: o_ascii = KEY_RIGHT;
            default:  o_valid = 1'b0;
         endcase
      end else if (w_is_letter) begin
         o_valid = 1'b1;
         o_ascii = (i_shift ^ i_caps) ? (w_letter - 8'h20) : w_letter;
      end else if (w_is_digit) begin
         // Caps lock only affects letters; digits follow shift alone.
         o_valid = 1'b1;
         o_ascii = i_shift ? w_digit_sh : w_digit;
      end else begin
         o_valid = 1'b1;
         case (i_code)
            SC_SPACE: o_ascii = 8'h20;
            SC_ENTER: o_ascii = 8'h0D;
            SC_BKSP:  o_ascii = 8'h08;
            SC_ESC:   o_ascii = 8'h1B;
            default:  o_valid = 1'b0;
         endcase
      end
   end
endmodule

// File: rtl/kbd_mmio.sv
// Memory-mapped PS/2 keyboard: scancode decode -> ASCII FIFO -> CPU registers + level irq.
// rx tick to FIFO entry takes two edges; a full FIFO drops new chars and sets sticky overflow.
module kbd_mmio
   import kbd_pkg::*;
#(
   parameter int         FIFO_DEPTH = 16,
   parameter logic [3:0] REGION     = 4'h3
)(
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic [7:0]  i_rx_data,
   input  logic        i_rx_done_tick,
   input  logic [31:0] i_addr_in,
   input  logic [31:0] i_data_in,
   input  logic        i_wr,
   input  logic        i_rd,
   output logic [31:0] o_mrd,
   output logic        o_irq
);
   localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

   kbd_state_t r_state, w_state_nxt;
   logic       r_shift, w_shift_nxt;
   logic       r_caps, w_caps_nxt;
   logic       r_push_req, w_push_nxt;
   logic [7:0] r_push_char;
   logic [7:0] w_xl_ascii;
   logic       w_xl_valid;

   logic [7:0]    r_mem [FIFO_DEPTH];
   logic [AW-1:0] r_wptr, r_rptr;
   logic [CW-1:0] r_count;
   logic          r_ovf;
   logic          r_irq_en;

   logic        w_sel, w_nempty, w_full, w_ctrl_wr, w_flush, w_pop, w_push, w_ovf_set;
   logic [7:0]  w_head, w_cnt8;
   logic [8:0]  w_cnt9;
   logic [31:0] w_mrd;
   logic        w_unused;

   kbd_scan_xlate u_xlate (
      .i_code  (i_rx_data),
      .i_ext   (r_state == ST_EXT),
      .i_shift (r_shift),
      .i_caps  (r_caps),
      .o_ascii (w_xl_ascii),
      .o_valid (w_xl_valid)
   );

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         r_state     <= ST_IDLE;
         r_shift     <= 1'b0;
         r_caps      <= 1'b0;
         r_push_req  <= 1'b0;
         r_push_char <= 8'h00;
      end else begin
         r_state     <= w_state_nxt;
         r_shift     <= w_shift_nxt;
         r_caps      <= w_caps_nxt;
         r_push_req  <= w_push_nxt;
         r_push_char <= w_xl_ascii;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_shift_nxt = r_shift;
      w_caps_nxt  = r_caps;
      w_push_nxt  = 1'b0;
      if (i_rx_done_tick) begin
         case (r_state)
            ST_IDLE: begin
               if (i_rx_data == SC_BREAK)     w_state_nxt = ST_BRK;
               else if (i_rx_data == SC_EXT)  w_state_nxt = ST_EXT;
               else if (is_shift(i_rx_data))  w_shift_nxt = 1'b1;
               else if (i_rx_data == SC_CAPS) w_caps_nxt  = ~r_caps;
               else                           w_push_nxt  = w_xl_valid;
            end
            ST_BRK: begin
               if (is_shift(i_rx_data)) w_shift_nxt = 1'b0;
               w_state_nxt = ST_IDLE;
            end
            ST_EXT: begin
               if (i_rx_data == SC_BREAK) begin
                  w_state_nxt = ST_EXTBRK;
               end else begin
                  w_push_nxt  = w_xl_valid;
                  w_state_nxt = ST_IDLE;
               end
            end
            default: w_state_nxt = ST_IDLE;
         endcase
      end
   end

   assign w_sel     = (i_addr_in[31:28] == REGION);
   assign w_nempty  = (r_count != '0);
   assign w_full    = (r_count == FULL_CNT);
   assign w_ctrl_wr = w_sel & i_wr & (i_addr_in[3:2] == KBD_CTRL);
   assign w_flush   = w_ctrl_wr & i_data_in[2];
   assign w_pop     = w_sel & i_rd & (i_addr_in[3:2] == KBD_DATA) & w_nempty & ~w_flush;
   // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
   assign w_push    = r_push_req & ~w_flush & (~w_full | w_pop);
   assign w_ovf_set = r_push_req & ~w_flush & w_full & ~w_pop;

   always_ff @(posedge i_clk) begin
      if (w_push) r_mem[r_wptr] <= r_push_char;
   end

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         r_wptr   <= '0;
         r_rptr   <= '0;
         r_count  <= '0;
         r_ovf    <= 1'b0;
         r_irq_en <= 1'b0;
      end else begin
         if (w_ctrl_wr) begin
            r_irq_en <= i_data_in[0];
            if (i_data_in[1]) r_ovf <= 1'b0;
         end
         if (w_ovf_set) r_ovf <= 1'b1;
         if (w_flush) begin
            r_rptr  <= r_wptr;
            r_count <= '0;
         end else begin
            if (w_push) r_wptr <= r_wptr + AW'(1);
            if (w_pop)  r_rptr <= r_rptr + AW'(1);
            case ({w_push, w_pop})
               2'b10:   r_count <= r_count + CW'(1);
               2'b01:   r_count <= r_count - CW'(1);
               default: r_count <= r_count;
            endcase
         end
      end
   end

   assign w_head = r_mem[r_rptr];
   assign w_cnt9 = 9'(r_count);
   assign w_cnt8 = w_cnt9[8] ? 8'hFF : w_cnt9[7:0];

   always_comb begin
      w_mrd = 32'h0;
      if (w_sel) begin
         case (i_addr_in[3:2])
            KBD_DATA:   w_mrd = {23'h0, w_nempty, (w_nempty ? w_head : 8'h00)};
            KBD_STATUS: w_mrd = {16'h0, w_cnt8, 3'b000, r_caps, r_shift, r_irq_en, r_ovf, w_nempty};
            KBD_CTRL:   w_mrd = {31'h0, r_irq_en};
            default:    w_mrd = 32'h0;
         endcase
      end
   end

   assign o_mrd    = w_mrd;
   assign o_irq    = r_irq_en & w_nempty;
   assign w_unused = ^{i_addr_in[27:4], i_addr_in[1:0], i_data_in[31:3]};
endmodule
